// File: rtl/cpu_bridge_pkg.sv
// cpu_bridge_pkg: shared types and helpers for the 65C02 to AXI-Lite bridge.
// Holds the FSM encoding, AXI response codes and byte-lane helpers.
package cpu_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    RADDR,
    WRESP,
    RRESP,
    DONE
  } bridge_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [7:0] READ_ERR_DATA = 8'hFF;

  function automatic logic [7:0] lane_byte(
    input logic [31:0] word,
    input logic [1:0]  lane
  );
    return word[8*lane +: 8];
  endfunction

  function automatic logic [3:0] lane_strb(
    input logic [1:0] lane
  );
    return 4'b0001 << lane;
  endfunction

  // EXOKAY is meaningless on AXI-Lite, so any non-OKAY code is an error.
  function automatic logic resp_err(
    input logic [1:0] resp
  );
    logic err;
    case (resp)
      RESP_OKAY:   err = 1'b0;
      RESP_SLVERR: err = 1'b1;
      RESP_DECERR: err = 1'b1;
      default:     err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/cpu_axil_bridge.sv
// cpu_axil_bridge: holds a 65C02 with RDY while each bus cycle is
// replayed as one AXI4-Lite master transaction.
module cpu_axil_bridge
  import cpu_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [15:0]           i_cpu_addr,
  input  logic [7:0]            i_cpu_data_from_cpu,
  input  logic                  i_cpu_rwb,
  output logic [7:0]            o_cpu_data_from_dut,
  output logic                  o_cpu_rdy,
  output logic                  o_bus_err,
  input  logic                  i_err_clr,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [3:0]            o_wstrb,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  input  logic [1:0]            i_bresp,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rvalid,
  output logic                  o_rready
);

  bridge_state_t state;

  logic                  aw_done;
  logic                  w_done;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  b_hs;
  logic                  r_hs;
  logic                  aw_ok;
  logic                  w_ok;
  logic                  new_err;
  logic [ADDR_WIDTH-1:0] cpu_axi_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [7:0]            rd_byte;

  assign cpu_axi_addr =
    ADDR_WIDTH'({BASE_ADDR[31:16], i_cpu_addr});
  assign cpu_wdata =
    DATA_WIDTH'({4{i_cpu_data_from_cpu}});

  assign aw_hs = o_awvalid & i_awready;
  assign w_hs  = o_wvalid & i_wready;
  assign ar_hs = o_arvalid & i_arready;
  assign b_hs  = o_bready & i_bvalid;
  assign r_hs  = o_rready & i_rvalid;

  // A channel counts as done if it finished earlier or finishes now.
  assign aw_ok = aw_done | aw_hs;
  assign w_ok  = w_done | w_hs;

  assign new_err = (b_hs & resp_err(i_bresp))
                 | (r_hs & resp_err(i_rresp));

  assign rd_byte = resp_err(i_rresp)
                 ? READ_ERR_DATA
                 : lane_byte(i_rdata, o_araddr[1:0]);

  assign o_cpu_rdy = (state == DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= IDLE;
      aw_done             <= 1'b0;
      w_done              <= 1'b0;
      o_awaddr            <= '0;
      o_awvalid           <= 1'b0;
      o_wdata             <= '0;
      o_wstrb             <= 4'b0000;
      o_wvalid            <= 1'b0;
      o_bready            <= 1'b0;
      o_araddr            <= '0;
      o_arvalid           <= 1'b0;
      o_rready            <= 1'b0;
      o_cpu_data_from_dut <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_cpu_rwb) begin
            o_araddr  <= cpu_axi_addr;
            o_arvalid <= 1'b1;
            state     <= RADDR;
          end else begin
            o_awaddr  <= cpu_axi_addr;
            o_wdata   <= cpu_wdata;
            o_wstrb   <= lane_strb(i_cpu_addr[1:0]);
            o_awvalid <= 1'b1;
            o_wvalid  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= WADDR;
          end
        end
        WADDR: begin
          if (aw_hs) begin
            o_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            o_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            o_bready <= 1'b1;
            state    <= WRESP;
          end
        end
        RADDR: begin
          if (ar_hs) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state     <= RRESP;
          end
        end
        WRESP: begin
          if (b_hs) begin
            o_bready <= 1'b0;
            state    <= DONE;
          end
        end
        RRESP: begin
          if (r_hs) begin
            o_rready            <= 1'b0;
            o_cpu_data_from_dut <= rd_byte;
            state               <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A fresh error outranks a clear arriving in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bus_err <= 1'b0;
    end else if (new_err) begin
      o_bus_err <= 1'b1;
    end else if (i_err_clr) begin
      o_bus_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_axil_bridge.sv
// tb_cpu_axil_bridge: CPU driver plus AXI-Lite slave with a queued
// scoreboard and a transaction-level reference model.
module tb_cpu_axil_bridge;

  localparam logic [31:0] TB_BASE = 32'h1234_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rwb;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic        bus_err;
  logic        err_clr;
  logic        clr_a;
  logic        clr_b;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  assign err_clr = clr_a | clr_b;

  cpu_axil_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .BASE_ADDR (TB_BASE)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_cpu_addr         (cpu_addr),
    .i_cpu_data_from_cpu(cpu_wdata),
    .i_cpu_rwb          (cpu_rwb),
    .o_cpu_data_from_dut(cpu_rdata),
    .o_cpu_rdy          (cpu_rdy),
    .o_bus_err          (bus_err),
    .i_err_clr          (err_clr),
    .o_awaddr           (awaddr),
    .o_awvalid          (awvalid),
    .i_awready          (awready),
    .o_wdata            (wdata),
    .o_wstrb            (wstrb),
    .o_wvalid           (wvalid),
    .i_wready           (wready),
    .i_bresp            (bresp),
    .i_bvalid           (bvalid),
    .o_bready           (bready),
    .o_araddr           (araddr),
    .o_arvalid          (arvalid),
    .i_arready          (arready),
    .i_rdata            (rdata),
    .i_rresp            (rresp),
    .i_rvalid           (rvalid),
    .o_rready           (rready)
  );

  typedef struct {
    bit        rwb;
    bit [15:0] addr;
    bit [7:0]  wbyte;
    int        ad;
    int        rd;
    int        awd;
    int        wd;
    int        bd;
    bit [31:0] rdata;
    bit [1:0]  resp;
    bit        clr_idle;
    bit        clr_resp;
  } op_t;

  typedef struct {
    bit        rwb;
    bit [31:0] axaddr;
    bit [31:0] wdata;
    bit [3:0]  wstrb;
    bit [7:0]  rbyte;
    int        lat;
  } exp_t;

  op_t  slave_q[$];
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit [7:0] last_rd = 8'h00;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic fail_stop(string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired or protocol broken", name);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Reference model: what one CPU access must look like on the bus.
  function automatic exp_t model(op_t o);
    exp_t e;
    int   m;
    e.rwb    = o.rwb;
    e.axaddr = {TB_BASE[31:16], o.addr};
    e.wdata  = {4{o.wbyte}};
    e.wstrb  = 4'(1 << (o.addr % 4));
    if (o.rwb) begin
      if (o.resp != 2'b00) e.rbyte = 8'hFF;
      else e.rbyte = 8'(o.rdata >> (8 * (o.addr % 4)));
      last_rd = e.rbyte;
      e.lat   = 1 + (o.ad + 1) + (o.rd + 1);
    end else begin
      m       = (o.awd > o.wd) ? o.awd : o.wd;
      e.rbyte = last_rd;
      e.lat   = 1 + (m + 1) + (o.bd + 1);
    end
    return e;
  endfunction

  function automatic op_t mk(bit rwb, bit [15:0] a, bit [7:0] wb,
                             bit [31:0] rdw, bit [1:0] resp,
                             int d0, int d1, int d2,
                             bit ci, bit cr);
    op_t o;
    o.rwb = rwb; o.addr = a; o.wbyte = wb;
    o.rdata = rdw; o.resp = resp;
    o.ad = d0; o.rd = d1;
    o.awd = d0; o.wd = d1; o.bd = d2;
    o.clr_idle = ci; o.clr_resp = cr;
    return o;
  endfunction

  task automatic issue(op_t o);
    exp_t e;
    e         = model(o);
    cpu_addr  = o.addr;
    cpu_rwb   = o.rwb;
    cpu_wdata = o.wbyte;
    clr_a     = o.clr_idle;
    slave_q.push_back(o);
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(posedge clk);
    #1 clr_a = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_rdy) break;
      n++;
      if (n > 300) fail_stop("rdy_timeout");
    end
    @(posedge clk);
    #1;
  endtask

  // AXI-Lite slave: per-channel wait counters, -1 means idle.
  initial begin : slave
    op_t cr;
    op_t cw;
    int  ar_c, r_c, aw_c, w_c, b_c;
    bit  aw_ok, w_ok, rd_act, wr_act;
    bit  p_ar, p_r, p_aw, p_w, p_b;
    ar_c = -1; r_c = -1; aw_c = -1; w_c = -1; b_c = -1;
    aw_ok = 0; w_ok = 0; rd_act = 0; wr_act = 0;
    p_ar = 0; p_r = 0; p_aw = 0; p_w = 0; p_b = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    clr_b = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ar_c = -1; r_c = -1; aw_c = -1; w_c = -1; b_c = -1;
        aw_ok = 0; w_ok = 0; rd_act = 0; wr_act = 0;
        p_ar = 0; p_r = 0; p_aw = 0; p_w = 0; p_b = 0;
        arready = 0; rvalid = 0; awready = 0;
        wready = 0; bvalid = 0; clr_b = 0;
        continue;
      end
      if (p_ar) begin arready = 0; r_c = cr.rd; end
      if (p_r) begin rvalid = 0; clr_b = 0; rd_act = 0; end
      if (p_aw) begin awready = 0; aw_ok = 1; end
      if (p_w) begin wready = 0; w_ok = 1; end
      if (p_b) begin bvalid = 0; wr_act = 0; end
      if (aw_ok && w_ok) begin
        aw_ok = 0; w_ok = 0; b_c = cw.bd;
      end
      if (!rd_act && arvalid) begin
        if (slave_q.size() == 0) fail_stop("unexpected_ar");
        cr = slave_q.pop_front();
        rd_act = 1; ar_c = cr.ad;
      end
      if (!wr_act && (awvalid || wvalid)) begin
        if (slave_q.size() == 0) fail_stop("unexpected_aw");
        cw = slave_q.pop_front();
        wr_act = 1; aw_c = cw.awd; w_c = cw.wd;
      end
      if (ar_c == 0) arready = 1;
      if (ar_c >= 0) ar_c--;
      if (aw_c == 0) awready = 1;
      if (aw_c >= 0) aw_c--;
      if (w_c == 0) wready = 1;
      if (w_c >= 0) w_c--;
      if (r_c == 0) begin
        rvalid = 1; rdata = cr.rdata;
        rresp = cr.resp; clr_b = cr.clr_resp;
      end
      if (r_c >= 0) r_c--;
      if (b_c == 0) begin
        bvalid = 1; bresp = cw.resp;
      end
      if (b_c >= 0) b_c--;
      p_ar = arvalid && arready;
      p_r  = rvalid && rready;
      p_aw = awvalid && awready;
      p_w  = wvalid && wready;
      p_b  = bvalid && bready;
    end
  end

  // Monitor: mid-cycle sampling, pops the scoreboard on each RDY cycle.
  int        low_cnt = 0;
  bit        em = 0;
  bit        hs_err;
  bit [3:0]  ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0;
  bit        pv_ar = 0, pv_aw = 0, pv_w = 0;
  bit [31:0] p_araddr = 0, p_awaddr = 0, p_wdata = 0;
  bit [3:0]  p_wstrb = 0;
  bit [19:0] hs_req;
  exp_t      mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      low_cnt = 0; em = 0;
      ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0;
      pv_ar = 0; pv_aw = 0; pv_w = 0;
    end else begin
      check("bus_err", bus_err, em);
      if (pv_ar)
        check("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
      if (pv_aw)
        check("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (pv_w)
        check("w_stable", {wvalid, wstrb, wdata},
              {1'b1, p_wstrb, p_wdata});
      if (arvalid && arready) begin
        ar_n++;
        if (exp_q.size() != 0)
          check("araddr", araddr, exp_q[0].axaddr);
      end
      if (awvalid && awready) begin
        aw_n++;
        if (exp_q.size() != 0)
          check("awaddr", awaddr, exp_q[0].axaddr);
      end
      if (wvalid && wready) begin
        w_n++;
        if (exp_q.size() != 0) begin
          check("wdata", wdata, exp_q[0].wdata);
          check("wstrb", wstrb, exp_q[0].wstrb);
        end
      end
      if (bvalid && bready) b_n++;
      if (rvalid && rready) r_n++;
      hs_err = (rvalid && rready && rresp != 2'b00)
            || (bvalid && bready && bresp != 2'b00);
      if (cpu_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rdy", 1'b1, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rdy_low_cycles", low_cnt, mon_e.lat);
          check("cpu_rdata", cpu_rdata, mon_e.rbyte);
          hs_req = mon_e.rwb ? 20'h11000 : 20'h00111;
          check("handshakes", {ar_n, r_n, aw_n, w_n, b_n}, hs_req);
        end
        low_cnt = 0;
        ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0;
      end else begin
        low_cnt++;
      end
      em = hs_err ? 1'b1 : (err_clr ? 1'b0 : em);
      pv_ar = arvalid && !arready;
      pv_aw = awvalid && !awready;
      pv_w  = wvalid && !wready;
      p_araddr = araddr; p_awaddr = awaddr;
      p_wdata = wdata; p_wstrb = wstrb;
    end
  end

  op_t dir_ops[$];
  op_t o;
  int  r;

  initial begin
    rst_n = 0; clr_a = 0;
    cpu_addr = 0; cpu_rwb = 1; cpu_wdata = 0;
    dir_ops.push_back(mk(1, 16'h0102, 0, 32'hDDCCBBAA, 2'b00,
                         0, 0, 0, 0, 0));
    dir_ops.push_back(mk(0, 16'h0003, 8'h5A, 0, 2'b00,
                         0, 3, 0, 0, 0));
    dir_ops.push_back(mk(1, 16'h2001, 0, 32'h11223344, 2'b00,
                         5, 6, 0, 0, 0));
    dir_ops.push_back(mk(1, 16'h0040, 0, 32'h01020304, 2'b11,
                         0, 0, 0, 0, 0));
    dir_ops.push_back(mk(1, 16'h0041, 0, 32'h0000AB00, 2'b00,
                         1, 0, 0, 1, 0));
    dir_ops.push_back(mk(1, 16'h0042, 0, 32'h55555555, 2'b10,
                         0, 1, 0, 0, 1));
    dir_ops.push_back(mk(0, 16'h1000, 8'h77, 0, 2'b00,
                         1, 1, 1, 1, 0));
    dir_ops.push_back(mk(1, 16'hFFFC, 0, 32'hCAFEBABE, 2'b00,
                         0, 0, 0, 0, 0));
    dir_ops.push_back(mk(0, 16'h3332, 8'hC3, 0, 2'b10,
                         2, 0, 2, 0, 0));

    issue(dir_ops[0]);
    repeat (3) @(posedge clk);
    #2;
    check("rst_ctrl",
          {cpu_rdy, cpu_rdata, bus_err, awvalid, wvalid,
           arvalid, bready, rready}, 0);
    check("rst_addr", {awaddr, araddr}, 0);
    check("rst_wdata", {wdata, wstrb}, 0);
    #1 rst_n = 1;
    wait_done();
    for (int i = 1; i < dir_ops.size(); i++) begin
      issue(dir_ops[i]);
      wait_done();
    end

    issue(mk(0, 16'h0555, 8'hE1, 0, 2'b00, 8, 8, 0, 0, 0));
    @(posedge clk);
    #1 clr_a = 0;
    @(posedge clk);
    #2;
    check("pre_rst_wvalids", {awvalid, wvalid}, 2'b11);
    rst_n = 0;
    #1;
    check("mid_rst_outputs",
          {awvalid, wvalid, arvalid, bready, rready, cpu_rdy}, 0);
    exp_q.delete();
    slave_q.delete();
    last_rd = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    issue(mk(1, 16'h0103, 0, 32'h9A000000, 2'b00, 0, 0, 0, 0, 0));
    #1 rst_n = 1;
    wait_done();

    for (int i = 0; i < 60; i++) begin
      o.rwb   = 1'($urandom_range(0, 1));
      o.addr  = 16'($urandom);
      o.wbyte = 8'($urandom);
      o.rdata = $urandom;
      r = int'($urandom_range(0, 7));
      o.ad  = int'($urandom_range(0, (r == 7) ? 8 : 3));
      o.rd  = int'($urandom_range(0, 3));
      o.awd = int'($urandom_range(0, 4));
      o.wd  = int'($urandom_range(0, 4));
      o.bd  = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 7));
      o.resp = (r == 0) ? 2'b11 : (r == 1) ? 2'b10 :
               (r == 2) ? 2'b01 : 2'b00;
      o.clr_idle = ($urandom_range(0, 4) == 0);
      o.clr_resp = ($urandom_range(0, 5) == 0);
      issue(o);
      wait_done();
    end

    if (exp_q.size() != 0) check("leftover_exp", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
